// File: rtl/complex_mult_pkg.sv
// Shared types and helpers for the complex multiplier datapath.
// The transmit stage uses the state enum and the per-product word count.
package complex_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ_HI,
    REQ_LO,
    DONE
  } tx_state_t;

  // Number of host-bus words needed to carry one {im, re} product.
  function automatic int tx_word_count(input int result_w, input int data_w);
    return (2 * result_w) / data_w;
  endfunction

endpackage

// File: rtl/result_tx_if.sv
// Product-in / host-word-out signal bundle for the result transmit stage.
// The slave side is the transmitter; the master side feeds it and plays the host.
interface result_tx_if #(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 16
);
  logic                load;
  logic [RESULT_W-1:0] result_re;
  logic [RESULT_W-1:0] result_im;
  logic                ack;
  logic [DATA_W-1:0]   data_out;
  logic                req;
  logic                busy;
  logic                done;

  modport master (
    output load, result_re, result_im, ack,
    input  data_out, req, busy, done
  );

  modport slave (
    input  load, result_re, result_im, ack,
    output data_out, req, busy, done
  );
endinterface

// File: rtl/result_tx_word_shifter.sv
// Capture register for one product, split into DATA_W lanes.
// Parallel load on capture; shifts one lane toward the output on next.
module word_shifter
  import complex_mult_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  capture,
  input  logic                  next,
  input  logic [2*RESULT_W-1:0] load_data,
  output logic [DATA_W-1:0]     word_out
);

  localparam int WORDS = tx_word_count(RESULT_W, DATA_W);

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_lane
      logic [DATA_W-1:0] lane_q;
      logic [DATA_W-1:0] lane_d;
      logic [DATA_W-1:0] shift_in;

      // The top lane backfills with zeros as words drain out.
      if (gi == WORDS - 1) begin : g_top
        assign shift_in = '0;
      end else begin : g_mid
        assign shift_in = g_lane[gi+1].lane_q;
      end

      always_comb begin
        lane_d = lane_q;
        if (capture) begin
          lane_d = load_data[gi*DATA_W +: DATA_W];
        end else if (next) begin
          lane_d = shift_in;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          lane_q <= '0;
        end else begin
          lane_q <= lane_d;
        end
      end
    end
  endgenerate

  assign word_out = g_lane[0].lane_q;

endmodule

// File: rtl/result_tx.sv
// Sends one captured complex product to the host, LS word first,
// one word per 4-phase req/ack handshake, then pulses done.
module result_tx
  import complex_mult_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 16
) (
  input logic         clk,
  input logic         reset_n,
  result_tx_if.slave  bus
);

  localparam int WORDS = tx_word_count(RESULT_W, DATA_W);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  generate
    if (RESULT_W % DATA_W != 0) begin : g_bad_width
      $error("result_tx: RESULT_W must be an integer multiple of DATA_W");
    end
  endgenerate

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req_q, req_d;
  logic             capture;
  logic             next;

  word_shifter #(
    .DATA_W   (DATA_W),
    .RESULT_W (RESULT_W)
  ) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture),
    .next      (next),
    .load_data ({bus.result_im, bus.result_re}),
    .word_out  (bus.data_out)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    req_d   = req_q;
    capture = 1'b0;
    next    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (bus.load) begin
          capture = 1'b1;
          count_d = '0;
          state_d = SETUP;
        end
      end
      // A host still holding ack from the previous word must release it first.
      SETUP: begin
        if (!bus.ack) begin
          req_d   = 1'b1;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (bus.ack) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!bus.ack) begin
          if (count_q == LAST_WORD) begin
            state_d = DONE;
          end else begin
            count_d = count_q + 1'b1;
            next    = 1'b1;
            state_d = SETUP;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

  assign bus.req  = req_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule
